// File: rtl/dc_token_pkg.sv
// Shared helpers for the token-based dual-clock slice.
// Build option: `DC_TOKEN_TX_SYNC3_EN selects a three-flop readpointer synchronizer (two flops otherwise).
package dc_token_pkg;

`ifdef DC_TOKEN_TX_SYNC3_EN
    localparam int unsigned DC_SYNC_STAGES = 3;
`else
    localparam int unsigned DC_SYNC_STAGES = 2;
`endif

    // Helpers work on a fixed wide vector; callers zero-extend and pass the live width n.
    localparam int unsigned DC_MAX_SLOTS = 64;
    localparam int unsigned DC_IDX_W     = 6;

    function automatic logic [DC_MAX_SLOTS-1:0] rotl_onehot(
        input logic [DC_MAX_SLOTS-1:0] v,
        input int unsigned             n
    );
        logic [DC_MAX_SLOTS-1:0] r;
        logic                    wrap;
        wrap = |(v & (DC_MAX_SLOTS'(1) << (n - 1)));
        r    = (v << 1) & ~(DC_MAX_SLOTS'(1) << n);
        r    = r | DC_MAX_SLOTS'(wrap);
        return r;
    endfunction

    function automatic logic [DC_IDX_W-1:0] onehot2idx(input logic [DC_MAX_SLOTS-1:0] v);
        logic [DC_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DC_MAX_SLOTS; i++) begin
            if (v[i]) idx = idx | DC_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dc_token_sync.sv
// Flop-chain synchronizer for the reader's one-hot readpointer; resets to slot 0.
module dc_token_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(1);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < STAGES; s++) stage_q[s] <= RST_VAL;
        end else begin
            stage_q[0] <= async_i;
            for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/dc_token_tx_slice.sv
// Writer half of the token dual-clock slice: local handshake, slot buffer, one-hot writetoken.
// Build option: `DC_TOKEN_TX_SYNC3_EN deepens the readpointer synchronizer to three flops.
module dc_token_tx_slice
    import dc_token_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_WIDTH = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [DATA_WIDTH-1:0]              data_i,
    output logic [$clog2(BUFFER_WIDTH)-1:0]    fill_o,
    output logic [BUFFER_WIDTH-1:0]            writetoken_o,
    output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_o,
    input  logic [BUFFER_WIDTH-1:0]            readpointer_async_i
);

    localparam int unsigned FILL_W = $clog2(BUFFER_WIDTH);

    logic [BUFFER_WIDTH-1:0] wt_q, wt_d;
    logic [BUFFER_WIDTH-1:0] rp_sync;
    logic [DATA_WIDTH-1:0]   slot_q [BUFFER_WIDTH];
    logic [DC_MAX_SLOTS-1:0] wt_rot;
    logic [DC_IDX_W-1:0]     idx_w, idx_r;
    logic [DC_IDX_W:0]       diff;
    logic                    full;
    logic                    we;

    dc_token_sync #(
        .WIDTH  (BUFFER_WIDTH),
        .STAGES (DC_SYNC_STAGES)
    ) u_rp_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (readpointer_async_i),
        .sync_o  (rp_sync)
    );

    // Full leaves one slot unused so the slot the reader owns is never overwritten.
    always_comb begin
        wt_rot = rotl_onehot(DC_MAX_SLOTS'(wt_q), BUFFER_WIDTH);
        full   = (wt_rot == DC_MAX_SLOTS'(rp_sync));
        we     = valid_i && !full;
        wt_d   = we ? BUFFER_WIDTH'(wt_rot) : wt_q;
    end

    always_comb begin
        idx_w = onehot2idx(DC_MAX_SLOTS'(wt_q));
        idx_r = onehot2idx(DC_MAX_SLOTS'(rp_sync));
        diff  = {1'b0, idx_w} - {1'b0, idx_r};
        if (idx_w < idx_r) diff = diff + (DC_IDX_W + 1)'(BUFFER_WIDTH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wt_q <= BUFFER_WIDTH'(1);
        end else begin
            wt_q <= wt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUFFER_WIDTH; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < BUFFER_WIDTH; i++) begin
                if (we && wt_q[i]) slot_q[i] <= data_i;
            end
        end
    end

    assign ready_o      = !full;
    assign fill_o       = FILL_W'(diff);
    assign writetoken_o = wt_q;

    for (genvar g = 0; g < BUFFER_WIDTH; g++) begin : g_data
        assign data_async_o[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
    end

`ifndef SYNTHESIS
    rp_onehot_a : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot(rp_sync))
        else $error("readpointer after synchronizer is not one-hot: %b", rp_sync);
`endif

endmodule

// File: tb/tb_dc_token_tx_slice.sv
// Self-checking bench for dc_token_tx_slice: vector table, hand sequences, randomized stream.
module tb_dc_token_tx_slice;

    localparam int B  = 8;
    localparam int DW = 32;
`ifdef DC_TOKEN_TX_SYNC3_EN
    localparam int S = 3;
`else
    localparam int S = 2;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            valid_i;
    logic            ready_o;
    logic [DW-1:0]   data_i;
    logic [2:0]      fill_o;
    logic [B-1:0]    writetoken_o;
    logic [B*DW-1:0] data_async_o;
    logic [B-1:0]    readpointer_async_i;

    dc_token_tx_slice #(.DATA_WIDTH(DW), .BUFFER_WIDTH(B)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .valid_i             (valid_i),
        .ready_o             (ready_o),
        .data_i              (data_i),
        .fill_o              (fill_o),
        .writetoken_o        (writetoken_o),
        .data_async_o        (data_async_o),
        .readpointer_async_i (readpointer_async_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: write count modulo B, reader index as seen S edges late, slot contents, ordered scoreboard.
    int            m_wr;
    int            m_seen [S];
    logic [DW-1:0] m_mem [B];
    logic [DW-1:0] sb [$];
    int            rd_idx;
    bit            last_hs;

    function automatic logic [B-1:0] oh(input int i);
        return B'(1) << i;
    endfunction

    function automatic int idx_of(input logic [B-1:0] v);
        int r = 0;
        for (int i = 0; i < B; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int m_fill();
        return (m_wr - m_seen[S-1] + B) % B;
    endfunction

    function automatic bit m_ready();
        return ((m_wr + 1) % B) != m_seen[S-1];
    endfunction

    task automatic chk(input string nm, input logic [B*DW-1:0] act, input logic [B*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0;
        for (int k = 0; k < S; k++) m_seen[k] = 0;
        for (int i = 0; i < B; i++) m_mem[i] = '0;
        sb.delete();
    endtask

    task automatic check_model();
        logic [B*DW-1:0] exp;
        for (int i = 0; i < B; i++) exp[i*DW +: DW] = m_mem[i];
        chk("ready", ready_o, m_ready());
        chk("fill", fill_o, m_fill());
        chk("writetoken", writetoken_o, oh(m_wr));
        chk("slots", data_async_o, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        last_hs = valid_i && m_ready();
        if (last_hs) begin
            m_mem[m_wr] = data_i;
            sb.push_back(data_i);
            m_wr = (m_wr + 1) % B;
        end
        for (int k = S - 1; k > 0; k--) m_seen[k] = m_seen[k-1];
        m_seen[0] = idx_of(readpointer_async_i);
        @(negedge clk_i);
        check_model();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        valid_i = 1'b0;
        data_i = '0;
        rd_idx = 0;
        readpointer_async_i = oh(0);
        repeat (2) @(negedge clk_i);
        model_reset();
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_fill", fill_o, 0);
        chk("rst_wt", writetoken_o, 8'h01);
        chk("rst_slots", data_async_o, '0);
    endtask

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic [B-1:0]  rp;
        logic          exp_ready;
        logic [2:0]    exp_fill;
        logic [B-1:0]  exp_wt;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [B-1:0] hist0, hist1;
        logic [DW-1:0] exp_w;
        int words, reads;

        vecs[0] = '{1'b1, 32'hA5A5_0001, 8'h01, 1'b1, 3'd1, 8'h02};
        vecs[1] = '{1'b1, 32'h1111_0002, 8'h01, 1'b1, 3'd2, 8'h04};
        vecs[2] = '{1'b1, 32'h2222_0003, 8'h01, 1'b1, 3'd3, 8'h08};
        vecs[3] = '{1'b1, 32'h3333_0004, 8'h01, 1'b1, 3'd4, 8'h10};
        vecs[4] = '{1'b1, 32'h4444_0005, 8'h01, 1'b1, 3'd5, 8'h20};
        vecs[5] = '{1'b1, 32'h5555_0006, 8'h01, 1'b1, 3'd6, 8'h40};
        vecs[6] = '{1'b1, 32'h6666_0007, 8'h01, 1'b0, 3'd7, 8'h80};
        vecs[7] = '{1'b1, 32'hDEAD_BEEF, 8'h01, 1'b0, 3'd7, 8'h80};

        // T1/T2/T3: reset, then fill to capacity with the reader parked on slot 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            valid_i = vecs[i].valid;
            data_i = vecs[i].data;
            readpointer_async_i = vecs[i].rp;
            step();
            chk($sformatf("vec%0d_ready", i), ready_o, vecs[i].exp_ready);
            chk($sformatf("vec%0d_fill", i), fill_o, vecs[i].exp_fill);
            chk($sformatf("vec%0d_wt", i), writetoken_o, vecs[i].exp_wt);
        end
        valid_i = 1'b0;
        chk("t3_slot0", data_async_o[0 +: DW], 32'hA5A5_0001);
        chk("t3_slot7_untouched", data_async_o[7*DW +: DW], 32'h0);

        // T4: reader frees slot 0; ready rises only after the synchronizer latency.
        rd_idx = 1;
        readpointer_async_i = oh(1);
        for (int c = 1; c <= S; c++) begin
            step();
            chk($sformatf("t4_ready_c%0d", c), ready_o, (c == S) ? 1 : 0);
        end
        valid_i = 1'b1;
        data_i = 32'h7777_0007;
        step();
        valid_i = 1'b0;
        chk("t4_slot7", data_async_o[7*DW +: DW], 32'h7777_0007);
        chk("t4_wt_wrap", writetoken_o, 8'h01);
        chk("t4_fill_wrap", fill_o, 7);
        chk("t4_full_again", ready_o, 0);

        // T5: randomized stream against an in-order reader that sees the token two cycles late.
        do_reset();
        words = 0;
        reads = 0;
        hist0 = 8'h01;
        hist1 = 8'h01;
        for (int cyc = 0; cyc < 3000 && (words < 40 || reads < 40); cyc++) begin
            if (!valid_i && words < 40 && $urandom_range(0, 1) == 1) begin
                valid_i = 1'b1;
                data_i = $urandom;
            end
            step();
            if (last_hs) begin
                words++;
                valid_i = 1'b0;
            end
            if (idx_of(hist1) != rd_idx && $urandom_range(0, 2) != 0) begin
                if (sb.size() == 0) begin
                    chk("t5_unexpected_token", writetoken_o, oh(m_wr));
                    exp_w = 'x;
                end else begin
                    exp_w = sb.pop_front();
                end
                chk($sformatf("t5_read%0d", reads), data_async_o[rd_idx*DW +: DW], exp_w);
                reads++;
                rd_idx = (rd_idx + 1) % B;
                readpointer_async_i = oh(rd_idx);
            end
            hist1 = hist0;
            hist0 = writetoken_o;
        end
        valid_i = 1'b0;
        chk("t5_words", words, 40);
        chk("t5_reads", reads, 40);

        // T6: asynchronous reset in the middle of a burst with four words in flight.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i = $urandom;
            step();
        end
        valid_i = 1'b0;
        chk("t6_fill4", fill_o, 4);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_async_ready", ready_o, 1);
        chk("t6_async_fill", fill_o, 0);
        chk("t6_async_wt", writetoken_o, 8'h01);
        chk("t6_async_slots", data_async_o, '0);
        model_reset();
        rd_idx = 0;
        readpointer_async_i = oh(0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (S + 1) step();
        chk("t6_reader_empty", writetoken_o, readpointer_async_i);
        chk("t6_fill_after", fill_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
